// File: rtl/label_sram_arb.sv
// Two-requester arbiter for the single-port label SRAM, with a full zero-fill sweep.
// Requests are granted combinationally; SRAM controls are registered; read data returns two cycles after the grant.
//
// state | meaning
// ARB   | grant m0/m1 accesses, alternating priority under contention
// CLEAR | write 0x00 to addresses 0..1023, one per cycle; no grants
module label_sram_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_start,
  output logic       busy,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [9:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_gnt,
  output logic       m0_rvalid,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [9:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_gnt,
  output logic       m1_rvalid,
  output logic [7:0] rdata,
  output logic [9:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_wen,
  input  logic [7:0] sram_q
);

  localparam logic ARB   = 1'b0;
  localparam logic CLEAR = 1'b1;

  logic       state;
  logic [9:0] sweep_cnt;
  logic       last_m1;
  logic       rd0_pend;
  logic       rd1_pend;
  logic       arb_open;

  // A clr_start in ARB takes the cycle even if requests are pending.
  always_comb begin
    arb_open = (state == ARB) && !reset && !clr_start;
    m0_gnt   = arb_open && m0_req && (!m1_req || last_m1);
    m1_gnt   = arb_open && m1_req && (!m0_req || !last_m1);
  end

  assign busy  = (state == CLEAR);
  assign rdata = sram_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      sweep_cnt <= 10'd0;
      last_m1   <= 1'b1;
      sram_a    <= 10'd0;
      sram_d    <= 8'd0;
      sram_wen  <= 1'b1;
      rd0_pend  <= 1'b0;
      rd1_pend  <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      // Read pipeline keeps running through CLEAR so in-flight reads still land.
      rd0_pend  <= m0_gnt && !m0_we;
      rd1_pend  <= m1_gnt && !m1_we;
      m0_rvalid <= rd0_pend;
      m1_rvalid <= rd1_pend;

      if (m0_gnt) begin
        last_m1 <= 1'b0;
      end else if (m1_gnt) begin
        last_m1 <= 1'b1;
      end

      case (state)
        ARB: begin
          if (clr_start) begin
            state     <= CLEAR;
            sweep_cnt <= 10'd0;
          end
        end
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 10'd1;
          if (sweep_cnt == 10'd1023) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase

      if (state == CLEAR) begin
        sram_a   <= sweep_cnt;
        sram_d   <= 8'd0;
        sram_wen <= 1'b0;
      end else if (m0_gnt) begin
        sram_a   <= m0_addr;
        sram_d   <= m0_wdata;
        sram_wen <= !m0_we;
      end else if (m1_gnt) begin
        sram_a   <= m1_addr;
        sram_d   <= m1_wdata;
        sram_wen <= !m1_we;
      end else begin
        // Idle: address is held so the SRAM pins stay quiet.
        sram_d   <= 8'd0;
        sram_wen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_label_sram_arb.sv
// Bench for label_sram_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_label_sram_arb;

  logic       clk;
  logic       reset;
  logic       clr_start;
  logic       busy;
  logic       m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [9:0] m0_addr;
  logic [7:0] m0_wdata;
  logic       m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [9:0] m1_addr;
  logic [7:0] m1_wdata;
  logic [7:0] rdata;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic [7:0] sram_q;

  int checks = 0;
  int failures = 0;

  label_sram_arb dut (
    .clk(clk), .reset(reset), .clr_start(clr_start), .busy(busy),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen),
    .sram_q(sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // SRAM: synchronous read (q follows the presented address one cycle later), active-low write.
  logic [7:0] sram_mem [1024];
  initial begin
    logic [7:0] q_next;
    for (int i = 0; i < 1024; i++) sram_mem[i] = 8'(i * 7 + 3);
    sram_q = 8'h00;
    forever begin
      @(posedge clk);
      q_next = sram_mem[sram_a];
      if (sram_wen == 1'b0) sram_mem[sram_a] = sram_d;
      sram_q = q_next;
    end
  end

  // Reference model: tracks label contents, remaining sweep length, last winner
  // and a queue of promised read returns; compares every cycle at negedge.
  typedef struct {
    longint     due;
    bit         who;
    logic [7:0] data;
  } rd_t;

  initial begin
    logic [7:0] mem_ref [1024];
    rd_t        pend[$];
    rd_t        r;
    bit         model_on;
    int         clear_left;
    int         clear_idx;
    bit         last_was_m1;
    logic [9:0] e_a;
    logic [7:0] e_d;
    logic       e_wen;
    logic       e_g0, e_g1, e_busy, e_rv0, e_rv1;
    logic [7:0] e_rd;
    longint     mcyc;
    for (int i = 0; i < 1024; i++) mem_ref[i] = 8'(i * 7 + 3);
    model_on = 0; clear_left = 0; clear_idx = 0; last_was_m1 = 1;
    e_a = 0; e_d = 0; e_wen = 1; mcyc = 0;
    forever begin
      @(negedge clk);
      e_busy = (clear_left > 0);
      e_g0 = 0; e_g1 = 0;
      if (!reset && !e_busy && !clr_start) begin
        if (m0_req && m1_req) begin
          e_g0 = last_was_m1;
          e_g1 = !last_was_m1;
        end else begin
          e_g0 = m0_req;
          e_g1 = m1_req;
        end
      end
      e_rv0 = 0; e_rv1 = 0; e_rd = 0;
      foreach (pend[k]) begin
        if (pend[k].due == mcyc) begin
          if (pend[k].who) e_rv1 = 1; else e_rv0 = 1;
          e_rd = pend[k].data;
        end
      end
      while (pend.size() > 0 && pend[0].due <= mcyc) void'(pend.pop_front());

      if (model_on) begin
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_gnt0", 32'(m0_gnt), 32'(e_g0));
        chk("m_gnt1", 32'(m1_gnt), 32'(e_g1));
        chk("m_sram_a", 32'(sram_a), 32'(e_a));
        chk("m_sram_d", 32'(sram_d), 32'(e_d));
        chk("m_sram_wen", 32'(sram_wen), 32'(e_wen));
        chk("m_rvalid0", 32'(m0_rvalid), 32'(e_rv0));
        chk("m_rvalid1", 32'(m1_rvalid), 32'(e_rv1));
        if (e_rv0 || e_rv1) chk("m_rdata", 32'(rdata), 32'(e_rd));
      end

      if (reset) begin
        model_on = 1;
        clear_left = 0;
        last_was_m1 = 1;
        e_a = 0; e_d = 0; e_wen = 1;
        pend.delete();
      end else if (e_busy) begin
        e_a = 10'(clear_idx); e_d = 0; e_wen = 0;
        mem_ref[clear_idx] = 8'h00;
        clear_idx++;
        clear_left--;
      end else if (clr_start) begin
        clear_left = 1024;
        clear_idx = 0;
        e_d = 0; e_wen = 1;
      end else if (e_g0 || e_g1) begin
        e_a   = e_g0 ? m0_addr : m1_addr;
        e_d   = e_g0 ? m0_wdata : m1_wdata;
        e_wen = e_g0 ? !m0_we : !m1_we;
        if (!e_wen) begin
          mem_ref[e_a] = e_d;
        end else begin
          r.due = mcyc + 2; r.who = e_g1; r.data = mem_ref[e_a];
          pend.push_back(r);
        end
        last_was_m1 = e_g1;
      end else begin
        e_d = 0; e_wen = 1;
      end
      mcyc++;
    end
  end

  int c_m0r [5] = '{1, 1, 1, 1, 1};
  int c_m0a [5] = '{'h10, 'h12, 'h12, 'h10, 'h10};
  int c_m1r [5] = '{1, 1, 1, 1, 0};
  int c_m1a [5] = '{'h11, 'h11, 'h13, 'h13, 'h00};
  int c_g0  [5] = '{1, 0, 1, 0, 1};
  int c_g1  [5] = '{0, 1, 0, 1, 0};
  int c_who [5] = '{0, 1, 0, 1, 0};
  int c_dat [5] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0};

  initial begin
    int  bsy, bad, gn, nz, cnt, rv;
    bit  g0, g1;
    reset = 1; clr_start = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    @(negedge clk);
    chk("rst_gnt0", 32'(m0_gnt), 0);
    tick; tick;
    reset = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wen", 32'(sram_wen), 1);
    chk("rst_a", 32'(sram_a), 0);

    // Single write then read at 0x21F.
    tick;
    m0_req = 1; m0_we = 1; m0_addr = 10'h21F; m0_wdata = 8'h05;
    @(negedge clk);
    chk("wr_gnt", 32'(m0_gnt), 1);
    tick;
    m0_we = 0; m0_wdata = 0;
    @(negedge clk);
    chk("rd_gnt", 32'(m0_gnt), 1);
    chk("wr_wen", 32'(sram_wen), 0);
    chk("wr_a", 32'(sram_a), 'h21F);
    chk("wr_d", 32'(sram_d), 5);
    tick;
    m0_req = 0;
    @(negedge clk);
    chk("rd_wen", 32'(sram_wen), 1);
    chk("rd_rvalid_early", 32'(m0_rvalid), 0);
    tick;
    @(negedge clk);
    chk("rd_rvalid", 32'(m0_rvalid), 1);
    chk("rd_data", 32'(rdata), 5);
    chk("rd_m1_rvalid", 32'(m1_rvalid), 0);

    // Preload 0x10..0x13, reset so m0 is favoured, then contend with reads.
    for (int i = 0; i < 4; i++) begin
      tick;
      m0_req = 1; m0_we = 1; m0_addr = 10'(16 + i); m0_wdata = 8'(8'hA0 + i);
      @(negedge clk);
      chk("pre_gnt", 32'(m0_gnt), 1);
    end
    tick; m0_req = 0; m0_we = 0;
    tick;
    reset = 1;
    tick;
    reset = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        m0_req = c_m0r[c] != 0; m0_addr = 10'(c_m0a[c]);
        m1_req = c_m1r[c] != 0; m1_addr = 10'(c_m1a[c]);
      end else begin
        m0_req = 0; m1_req = 0;
      end
      @(negedge clk);
      if (c < 5) begin
        chk("cont_g0", 32'(m0_gnt), 32'(c_g0[c]));
        chk("cont_g1", 32'(m1_gnt), 32'(c_g1[c]));
      end
      if (c >= 2) begin
        chk("cont_rv0", 32'(m0_rvalid), 32'(c_who[c-2] == 0));
        chk("cont_rv1", 32'(m1_rvalid), 32'(c_who[c-2] == 1));
        chk("cont_rdata", 32'(rdata), 32'(c_dat[c-2]));
      end
      tick;
    end

    // Clear versus a pending m1 read.
    clr_start = 1; m1_req = 1; m1_we = 0; m1_addr = 10'h11;
    @(negedge clk);
    chk("clr_start_g1", 32'(m1_gnt), 0);
    chk("clr_start_busy", 32'(busy), 0);
    tick;
    clr_start = 0;
    bsy = 0; bad = 0; gn = 0;
    @(negedge clk);
    while (busy === 1'b1 && bsy < 1100) begin
      if (m0_gnt || m1_gnt) gn++;
      if (bsy >= 1 && (sram_wen !== 1'b0 || 32'(sram_a) != bsy - 1 || sram_d !== 8'h00)) bad++;
      bsy++;
      tick;
      @(negedge clk);
    end
    chk("clr_busy_len", 32'(bsy), 1024);
    chk("clr_no_gnt", 32'(gn), 0);
    chk("clr_sweep", 32'(bad), 0);
    chk("clr_after_g1", 32'(m1_gnt), 1);
    chk("clr_last_a", 32'(sram_a), 1023);
    chk("clr_last_wen", 32'(sram_wen), 0);
    tick;
    m1_req = 0;
    tick; tick;
    nz = 0;
    for (int i = 0; i < 1024; i++) if (sram_mem[i] !== 8'h00) nz++;
    chk("clr_mem_zero", 32'(nz), 0);

    // Reset in the middle of a sweep, then restart.
    clr_start = 1;
    tick;
    clr_start = 0;
    repeat (500) tick;
    reset = 1; m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_a", 32'(sram_a), 499);
    chk("mid_rst_gnt", 32'(m0_gnt), 0);
    tick;
    reset = 0; m0_req = 0;
    @(negedge clk);
    chk("mid_after_busy", 32'(busy), 0);
    chk("mid_after_wen", 32'(sram_wen), 1);
    tick;
    clr_start = 1;
    tick;
    clr_start = 0;
    @(negedge clk);
    chk("restart_busy", 32'(busy), 1);
    tick;
    @(negedge clk);
    chk("restart_a", 32'(sram_a), 0);
    chk("restart_wen", 32'(sram_wen), 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1100) begin
      tick;
      @(negedge clk);
      cnt++;
    end
    chk("restart_len", 32'(cnt), 1023);

    // Reset one cycle after an m1 read grant.
    tick;
    m1_req = 1; m1_we = 0; m1_addr = 10'h033;
    @(negedge clk);
    chk("rr_gnt", 32'(m1_gnt), 1);
    tick;
    m1_req = 0; reset = 1;
    rv = 0;
    @(negedge clk);
    if (m1_rvalid === 1'b1) rv++;
    tick;
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m1_rvalid !== 1'b0) rv++;
      tick;
    end
    chk("rr_no_rvalid", 32'(rv), 0);

    // Randomized traffic; requesters hold until granted.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      tick;
      reset = ($urandom_range(0, 1499) == 0);
      clr_start = !reset && ($urandom_range(0, 1499) == 0);
      if (!m0_req || g0) begin
        m0_req = ($urandom_range(0, 2) != 0);
        m0_we = $urandom_range(0, 1) != 0;
        m0_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
        m0_wdata = 8'($urandom);
      end
      if (!m1_req || g1) begin
        m1_req = ($urandom_range(0, 2) != 0);
        m1_we = $urandom_range(0, 3) == 0;
        m1_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
        m1_wdata = 8'($urandom);
      end
    end
    reset = 0; clr_start = 0; m0_req = 0; m1_req = 0;
    repeat (4) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/label_sram_arb.md
LABEL_SRAM_ARB -- requirements
Module: label_sram_arb

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous active-high reset, reset; all state updates SHALL occur on the rising edge of clk.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clr_start  in  1  single-cycle pulse that starts a zero-fill of the label SRAM
- busy  out  1  high while the zero-fill sweep is running
- m0_req  in  1  requester 0 (labeling engine) access request
- m0_we  in  1  requester 0 access type: 1 = write, 0 = read
- m0_addr  in  10  requester 0 SRAM address
- m0_wdata  in  8  requester 0 write data
- m0_gnt  out  1  requester 0 access accepted this cycle
- m0_rvalid  out  1  rdata holds requester 0 read result
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid  same widths and meanings, for requester 1 (host readback/checker)
- rdata  out  8  shared read data, equal to sram_q
- sram_a  out  10  SRAM address (registered)
- sram_d  out  8  SRAM write data (registered)
- sram_wen  out  1  SRAM write enable, active-low: 0 = write, 1 = read/idle (registered)
- sram_q  in  8  SRAM read data, valid the cycle after the read address is presented

Function
REQ-003 The FSM SHALL have two states, ARB and CLEAR, and SHALL reset to ARB.
REQ-004 In ARB, a clr_start=1 SHALL move the FSM to CLEAR on the next edge and SHALL suppress both grants in that cycle, even when requests are pending.
REQ-005 In CLEAR, the block SHALL issue one write of 0x00 per cycle to addresses 0, 1, ..., 1023 in order, using a 10-bit sweep counter, for a total of exactly 1024 writes.
REQ-006 The cycle after the write to address 1023 is issued, the FSM SHALL return to ARB; busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-007 In CLEAR, m0_gnt and m1_gnt SHALL be 0, and clr_start SHALL be ignored.
REQ-008 In ARB, grants SHALL be combinational from the current requests; at most one of m0_gnt and m1_gnt SHALL be 1 in any cycle.
REQ-009 Arbitration:
- only one requester active: that requester is granted;
- both active: grant the requester that did not receive the most recent grant;
- after reset, m0 wins the first contended cycle.
REQ-010 The last-granted pointer SHALL update only in cycles where a grant is issued.
REQ-011 For a grant in cycle T, sram_a, sram_d and sram_wen SHALL carry the granted address, data and type in cycle T+1, with sram_wen = ~we.
REQ-012 For a read granted in cycle T, the matching mN_rvalid SHALL be 1 in cycle T+2 only, and rdata SHALL equal sram_q in that cycle. Read latency is 2 cycles; back-to-back reads SHALL give one rvalid per cycle.
REQ-013 A granted write SHALL produce no rvalid.
REQ-014 In a cycle with no grant and no clear write, the registered outputs in the next cycle SHALL be:
- sram_wen = 1;
- sram_a holding its previous value;
- sram_d = 0.
REQ-015 A requester SHALL hold req, we, addr and wdata stable until it sees gnt. An ungranted request SHALL NOT be dropped or reordered by the block.
REQ-016 An rvalid already in flight when CLEAR begins SHALL still be delivered at its scheduled cycle.

Reset
REQ-017 On reset=1 at a clock edge, the block SHALL set:
- state = ARB;
- busy = 0;
- sram_a = 0, sram_d = 0, sram_wen = 1;
- m0_rvalid = m1_rvalid = 0;
- sweep counter = 0;
- last-granted pointer = m1, so that m0 is favoured first.
REQ-018 While reset=1, m0_gnt and m1_gnt SHALL be 0.
REQ-019 A reset during CLEAR SHALL abort the sweep; the next clr_start SHALL restart the sweep at address 0.
REQ-020 A reset SHALL discard in-flight read pipeline entries, and no rvalid SHALL follow reset.

Verification
REQ-021 Clear sweep: pulse clr_start in ARB →
- busy = 1 for 1024 cycles;
- sram_wen = 0 with sram_a stepping 0..1023 and sram_d = 0;
- then busy = 0, and an SRAM model reads 0x00 at every address.
REQ-022 Single write/read: m0 writes 0x05 to address 0x21F, then reads address 0x21F →
- gnt is issued the same cycle as each request;
- sram_wen = 0 at T+1 for the write;
- m0_rvalid = 1 at T+2 with rdata = 0x05;
- m1_rvalid stays 0.
REQ-023 Contention: m0 and m1 both hold read requests for 4 cycles → grants alternate m0, m1, m0, m1, and rvalids alternate with 2-cycle latency and the correct data.
REQ-024 Clear versus request: clr_start and m1_req asserted in the same cycle → no grant in that cycle and none for 1024 cycles; m1 is granted in the first ARB cycle after the sweep.
REQ-025 Reset mid-sweep: assert reset at sweep address 500 →
- busy = 0 and sram_wen = 1 next cycle;
- a new clr_start restarts the sweep at sram_a = 0.
REQ-026 Reset with a read in flight: assert reset 1 cycle after an m1 read grant → m1_rvalid never asserts.
